// File: rtl/mux_config_ctrl.sv
// Command-driven console mux configuration controller with break-before-make selector switching.
// Optional readback port set and READ command enabled by defining MUXCTL_READBACK_EN.
module mux_config_ctrl #(
  parameter int unsigned INPUT_COUNT  = 4,
  parameter int unsigned OUTPUT_COUNT = 4,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    cmd_data,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  output logic [OUTPUT_COUNT*SEL_W-1:0] selectors,
  output logic [OUTPUT_COUNT-1:0]       enabled_out,
  output logic                          busy,
`ifdef MUXCTL_READBACK_EN
  output logic [7:0]                    rsp_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
`endif
  output logic                          err
);

  localparam int unsigned CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [1:0] OP_SET_SEL  = 2'b00;
  localparam logic [1:0] OP_SET_EN   = 2'b01;
  localparam logic [1:0] OP_READ     = 2'b10;
  localparam logic [1:0] OP_DEFAULTS = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_ARG, S_EXEC, S_GUARD, S_SWITCH, S_RESP
  } state_t;

  state_t                        state, state_next;
  logic [7:0]                    hdr_q, hdr_next;
  logic [7:0]                    arg_q, arg_next;
  logic [OUTPUT_COUNT-1:0]       en_mask, en_next;
  logic [OUTPUT_COUNT-1:0]       guard_mask, guard_next;
  logic [CNT_W-1:0]              cnt, cnt_next;
  logic [OUTPUT_COUNT*SEL_W-1:0] sel_next;
  logic                          err_next;
  logic                          accept;
  logic                          idx_ok, arg_ok;
  logic [SEL_W-1:0]              cur_sel;
  logic                          cur_en;
  logic [1:0]                    op;
  logic [5:0]                    idx;
`ifdef MUXCTL_READBACK_EN
  logic [7:0]                    rsp_data_next;
  logic                          rsp_valid_next;
`endif

  assign accept = cmd_valid & cmd_ready;
  assign op     = hdr_q[7:6];
  assign idx    = hdr_q[5:0];

  // State and configuration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      hdr_q       <= '0;
      arg_q       <= '0;
      en_mask     <= '0;
      guard_mask  <= '0;
      cnt         <= '0;
      selectors   <= '0;
      enabled_out <= '0;
      err         <= 1'b0;
      cmd_ready   <= 1'b0;
      busy        <= 1'b0;
`ifdef MUXCTL_READBACK_EN
      rsp_data    <= '0;
      rsp_valid   <= 1'b0;
`endif
    end else begin
      state       <= state_next;
      hdr_q       <= hdr_next;
      arg_q       <= arg_next;
      en_mask     <= en_next;
      guard_mask  <= guard_next;
      cnt         <= cnt_next;
      selectors   <= sel_next;
      enabled_out <= en_next & ~guard_next;
      err         <= err_next;
      cmd_ready   <= (state_next == S_IDLE) || (state_next == S_ARG);
      busy        <= !((state_next == S_IDLE) || (state_next == S_ARG));
`ifdef MUXCTL_READBACK_EN
      rsp_data    <= rsp_data_next;
      rsp_valid   <= rsp_valid_next;
`endif
    end
  end

  // Next-state, command decode and register updates
  always_comb begin
    state_next = state;
    hdr_next   = hdr_q;
    arg_next   = arg_q;
    en_next    = en_mask;
    guard_next = guard_mask;
    cnt_next   = cnt;
    sel_next   = selectors;
    err_next   = 1'b0;
`ifdef MUXCTL_READBACK_EN
    rsp_data_next  = rsp_data;
    rsp_valid_next = rsp_valid;
`endif
    cur_sel = '0;
    cur_en  = 1'b0;
    for (int i = 0; i < OUTPUT_COUNT; i++) begin
      if (idx == 6'(i)) begin
        cur_sel = selectors[i*SEL_W +: SEL_W];
        cur_en  = en_mask[i];
      end
    end
    idx_ok = idx < 6'(OUTPUT_COUNT);
    arg_ok = arg_q < 8'(INPUT_COUNT);

    case (state)
      S_IDLE: begin
        if (accept) begin
          hdr_next   = cmd_data;
          state_next = S_ARG;
        end
      end
      S_ARG: begin
        if (accept) begin
          arg_next   = cmd_data;
          state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        state_next = S_IDLE;
        case (op)
          OP_SET_SEL: begin
            if (!idx_ok || !arg_ok) begin
              err_next = 1'b1;
            end else if (arg_q[SEL_W-1:0] != cur_sel) begin
              for (int i = 0; i < OUTPUT_COUNT; i++) begin
                if (idx == 6'(i)) guard_next[i] = 1'b1;
              end
              cnt_next   = CNT_W'(GUARD_CYCLES - 1);
              state_next = S_GUARD;
            end
          end
          OP_SET_EN: en_next = arg_q[OUTPUT_COUNT-1:0];
          OP_READ: begin
`ifdef MUXCTL_READBACK_EN
            if (idx_ok) begin
              rsp_data_next    = 8'(cur_sel);
              rsp_data_next[7] = cur_en;
              rsp_valid_next   = 1'b1;
              state_next       = S_RESP;
            end else begin
              err_next = 1'b1;
            end
`else
            err_next = 1'b1;
`endif
          end
          OP_DEFAULTS: begin
            sel_next = '0;
            en_next  = '0;
          end
          default: err_next = 1'b1;
        endcase
      end
      S_GUARD: begin
        // Selector moves only while the output is held disabled
        if (cnt == '0) begin
          for (int i = 0; i < OUTPUT_COUNT; i++) begin
            if (idx == 6'(i)) sel_next[i*SEL_W +: SEL_W] = arg_q[SEL_W-1:0];
          end
          state_next = S_SWITCH;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_SWITCH: begin
        guard_next = '0;
        state_next = S_IDLE;
      end
      S_RESP: begin
`ifdef MUXCTL_READBACK_EN
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = S_IDLE;
        end
`else
        state_next = S_IDLE;
`endif
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_config_ctrl.sv
// Directed self-checking bench for mux_config_ctrl (default parameters).
// Exercises readback when MUXCTL_READBACK_EN is defined, otherwise checks READ rejection.
module tb_mux_config_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] selectors;
  logic [3:0]  enabled_out;
  logic        busy;
  logic        err;
`ifdef MUXCTL_READBACK_EN
  logic [7:0]  rsp_data;
  logic        rsp_valid;
  logic        rsp_ready;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;

  mux_config_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_data    (cmd_data),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .selectors   (selectors),
    .enabled_out (enabled_out),
    .busy        (busy),
`ifdef MUXCTL_READBACK_EN
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
`endif
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && err) err_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Presents one byte and returns just after the edge that accepts it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_timeout", 32'(cmd_ready), 32'd1);
    cmd_data  = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] h, input logic [7:0] a);
    send_byte(h);
    send_byte(a);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int low_cnt;
    int e0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
`ifdef MUXCTL_READBACK_EN
    rsp_ready = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_selectors", 32'(selectors), 32'h0);
    check("rst_enabled", 32'(enabled_out), 32'h0);
    check("rst_busy_err", {30'd0, busy, err}, 32'h0);
    rst_n = 1'b1;

    // Test 1: prior config, then reset mid-ARG
    send_cmd(8'h40, 8'h0F);
    send_cmd(8'h02, 8'h03);
    wait_idle();
    check("t1_prior_sel", 32'(selectors), 32'h0300);
    check("t1_prior_en", 32'(enabled_out), 32'hF);
    send_byte(8'h01);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_rst_sel", 32'(selectors), 32'h0);
    check("t1_rst_en", 32'(enabled_out), 32'h0);
    check("t1_rst_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_ready_after", 32'(cmd_ready), 32'd1);

    // Test 2: SET_EN 0x03 as the first header after reset
    e0 = err_cnt;
    send_cmd(8'h40, 8'h03);
    @(negedge clk);
    check("t2_exec_busy", 32'(busy), 32'd1);
    check("t2_exec_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("t2_enabled", 32'(enabled_out), 32'h3);
    check("t2_sel", 32'(selectors), 32'h0);
    check("t2_busy_done", 32'(busy), 32'd0);
    check("t2_no_err", 32'(err_cnt - e0), 32'd0);

    // Test 3: break-before-make on output 1, selector 0 -> 2
    send_cmd(8'h01, 8'h02);
    low_cnt = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!enabled_out[1]) low_cnt++;
      check($sformatf("t3_en1_c%0d", k), 32'(enabled_out[1]), (k >= 2 && k <= 6) ? 32'd0 : 32'd1);
      check($sformatf("t3_sel1_c%0d", k), 32'(selectors[7:4]), (k >= 6) ? 32'd2 : 32'd0);
      check($sformatf("t3_en0_c%0d", k), 32'(enabled_out[0]), 32'd1);
    end
    check("t3_low_cycles", 32'(low_cnt), 32'd5);
    check("t3_sel_final", 32'(selectors), 32'h0020);

    // Test 4: rejected SET_SEL (bad idx, bad arg)
    e0 = err_cnt;
    send_cmd(8'h05, 8'h01);
    @(negedge clk);
    check("t4_err_exec", 32'(err), 32'd0);
    @(negedge clk);
    check("t4_err_pulse", 32'(err), 32'd1);
    @(negedge clk);
    check("t4_err_clear", 32'(err), 32'd0);
    send_cmd(8'h00, 8'h07);
    wait_idle();
    repeat (2) @(negedge clk);
    check("t4_err_count", 32'(err_cnt - e0), 32'd2);
    check("t4_sel", 32'(selectors), 32'h0020);
    check("t4_en", 32'(enabled_out), 32'h3);

    // Test 6: READ output 1
    e0 = err_cnt;
    send_cmd(8'h81, 8'h00);
`ifdef MUXCTL_READBACK_EN
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_valid_%0d", k), 32'(rsp_valid), 32'd1);
      check($sformatf("t6_data_%0d", k), 32'(rsp_data), 32'h82);
      check($sformatf("t6_ready_%0d", k), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("t6_valid_drop", 32'(rsp_valid), 32'd0);
    check("t6_ready_back", 32'(cmd_ready), 32'd1);
    check("t6_no_err", 32'(err_cnt - e0), 32'd0);
`else
    @(negedge clk);
    @(negedge clk);
    check("t6_read_err", 32'(err), 32'd1);
    @(negedge clk);
    check("t6_err_count", 32'(err_cnt - e0), 32'd1);
    check("t6_cfg_kept", {12'd0, enabled_out, selectors}, {12'd0, 4'h3, 16'h0020});
`endif

    // Test 5: no-op SET_SEL, then DEFAULTS
    send_cmd(8'h00, 8'h00);
    @(negedge clk);
    check("t5_busy_exec", 32'(busy), 32'd1);
    check("t5_en_exec", 32'(enabled_out), 32'h3);
    @(negedge clk);
    check("t5_busy_done", 32'(busy), 32'd0);
    check("t5_en_after", 32'(enabled_out), 32'h3);
    send_cmd(8'hC0, 8'h00);
    wait_idle();
    check("t5_def_sel", 32'(selectors), 32'h0);
    check("t5_def_en", 32'(enabled_out), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
